// File: rtl/stream_pkg.sv
// Shared definitions for the multi-source stream controller: FSM state codes
// and the index-to-one-hot helper used to build producer enables.
package stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COMM  = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3
    } state_t;

    function automatic logic [31:0] idx_to_onehot(input logic [7:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/multi_src_stream_ctrl_edge_rise.sv
// Single-bit rising-edge detector; the history register clears on reset so a
// level already high at reset release reports one edge.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/multi_src_stream_ctrl.sv
// Session controller choosing one of N_CH producers, gating it on buffer
// backpressure and draining on stop. Optional drain timeout: STREAM_DRAIN_TIMEOUT_EN.
module multi_src_stream_ctrl
    import stream_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DW         = 16,
    parameter int CW         = 16,
    parameter int TO_CYCLES  = 1024,
    parameter bit PARITY_ODD = 1'b0,
    localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] start,
    input  logic            stop,
    input  logic            buf_full,
    input  logic            buf_empty,
    input  logic            src_valid,
    input  logic [DW-1:0]   dout,
    input  logic            dout_valid,
    output logic [N_CH-1:0] en,
    output logic [CHW-1:0]  sel,
    output logic [2:0]      state,
    output logic            busy,
    output logic [CW-1:0]   word_cnt,
    output logic            parity,
    output logic            drain_to
);

    logic [N_CH-1:0] start_rise;
    logic            stop_rise;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_start_edge
            edge_rise u_edge (.clk(clk), .rst(rst), .din(start[gi]), .rise(start_rise[gi]));
        end
    endgenerate

    edge_rise u_stop_edge (.clk(clk), .rst(rst), .din(stop), .rise(stop_rise));

    state_t          state_reg, state_next;
    logic [CHW-1:0]  sel_reg, sel_next;
    logic [N_CH-1:0] en_reg;
    logic [CW-1:0]   word_cnt_reg;
    logic            parity_reg;
    logic            one_start;
    logic [CHW-1:0]  rise_idx;
    logic            drain_timeout;
    int              rise_cnt;

    always_comb begin
        rise_cnt = 0;
        rise_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (start_rise[i]) begin
                rise_cnt = rise_cnt + 1;
                rise_idx = CHW'(i);
            end
        end
        one_start = (rise_cnt == 1);
    end

    // Only a session-opening start in IDLE may change the selected channel.
    wire accept_start = (state_reg == S_IDLE) && one_start;

    always_comb begin
        state_next = state_reg;
        sel_next   = accept_start ? rise_idx : sel_reg;
        case (state_reg)
            S_IDLE:  if (one_start) state_next = S_COMM;
            S_COMM:  if (stop_rise) state_next = S_DRAIN;
                     else if (buf_full) state_next = S_WAIT;
            S_WAIT:  if (stop_rise) state_next = S_DRAIN;
                     else if (!buf_full) state_next = S_COMM;
            S_DRAIN: if ((buf_empty && !dout_valid) || drain_timeout) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_reg <= '0;
        else     sel_reg <= sel_next;
    end

    // Enable is derived from the next state so it lines up with state==COMM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       en_reg <= '0;
        else if (state_next == S_COMM) en_reg <= N_CH'(idx_to_onehot(8'(sel_next)));
        else                           en_reg <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            word_cnt_reg <= '0;
        else if (accept_start)
            word_cnt_reg <= '0;
        else if (state_reg == S_COMM && src_valid && word_cnt_reg != {CW{1'b1}})
            word_cnt_reg <= word_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             parity_reg <= 1'b0;
        else if (dout_valid) parity_reg <= (^dout) ^ PARITY_ODD;
    end

`ifdef STREAM_DRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_reg;
    logic          drain_to_reg;

    assign drain_timeout = (state_reg == S_DRAIN) && (to_cnt_reg == TW'(TO_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     to_cnt_reg <= '0;
        else if (state_reg != S_DRAIN) to_cnt_reg <= '0;
        else                         to_cnt_reg <= to_cnt_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          drain_to_reg <= 1'b0;
        else if (accept_start)                            drain_to_reg <= 1'b0;
        else if (drain_timeout && !(buf_empty && !dout_valid)) drain_to_reg <= 1'b1;
    end

    assign drain_to = drain_to_reg;
`else
    assign drain_timeout = 1'b0;
    assign drain_to      = 1'b0;
`endif

    assign en       = en_reg;
    assign sel      = sel_reg;
    assign state    = state_reg;
    assign busy     = (state_reg != S_IDLE);
    assign word_cnt = word_cnt_reg;
    assign parity   = parity_reg;

endmodule

// File: tb/tb_multi_src_stream_ctrl.sv
// Directed bench for multi_src_stream_ctrl: an even-parity instance drives all
// checks, a second odd-parity instance on the same inputs checks inversion.
module tb_multi_src_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic        stop, buf_full, buf_empty, src_valid, dout_valid;
    logic [15:0] dout;

    logic [1:0]  en, en_b;
    logic [0:0]  sel, sel_b;
    logic [2:0]  state, state_b;
    logic        busy, busy_b, parity, parity_b, drain_to, drain_to_b;
    logic [15:0] word_cnt, word_cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_src_stream_ctrl #(.N_CH(2), .DW(16), .CW(16), .TO_CYCLES(8), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .buf_full(buf_full),
        .buf_empty(buf_empty), .src_valid(src_valid), .dout(dout), .dout_valid(dout_valid),
        .en(en), .sel(sel), .state(state), .busy(busy), .word_cnt(word_cnt),
        .parity(parity), .drain_to(drain_to));

    multi_src_stream_ctrl #(.N_CH(2), .DW(16), .CW(16), .TO_CYCLES(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .buf_full(buf_full),
        .buf_empty(buf_empty), .src_valid(src_valid), .dout(dout), .dout_valid(dout_valid),
        .en(en_b), .sel(sel_b), .state(state_b), .busy(busy_b), .word_cnt(word_cnt_b),
        .parity(parity_b), .drain_to(drain_to_b));

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic test_reset;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_word_cnt", 32'(word_cnt), 32'd0);
        chk("reset_parity", 32'(parity), 32'd0);
        chk("reset_drain_to", 32'(drain_to), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
    endtask

    task automatic test_session;
        start = 2'b10;
        tick(1);
        chk("sess_state", 32'(state), 32'd1);
        chk("sess_en", 32'(en), 32'b10);
        chk("sess_sel", 32'(sel), 32'd1);
        chk("sess_busy", 32'(busy), 32'd1);
        src_valid = 1'b1;
        tick(5);
        src_valid = 1'b0;
        tick(1);
        chk("sess_word_cnt", 32'(word_cnt), 32'd5);
        stop = 1'b1;
        tick(1);
        chk("sess_drain_state", 32'(state), 32'd3);
        chk("sess_drain_en", 32'(en), 32'd0);
        tick(1);
        chk("sess_idle_state", 32'(state), 32'd0);
        chk("sess_sel_held", 32'(sel), 32'd1);
        chk("sess_cnt_held", 32'(word_cnt), 32'd5);
        stop = 1'b0;
        start = 2'b00;
        tick(1);
        stop = 1'b1;
        tick(1);
        chk("idle_stop_ignored", 32'(state), 32'd0);
        stop = 1'b0;
        tick(1);
    endtask

    task automatic test_simultaneous;
        start = 2'b11;
        tick(1);
        chk("dual_state", 32'(state), 32'd0);
        chk("dual_en", 32'(en), 32'd0);
        start = 2'b00;
        tick(1);
        start = 2'b01;
        tick(1);
        chk("single_state", 32'(state), 32'd1);
        chk("single_en", 32'(en), 32'b01);
        chk("single_sel", 32'(sel), 32'd0);
        chk("single_cnt_clear", 32'(word_cnt), 32'd0);
    endtask

    task automatic test_backpressure;
        start = 2'b11;
        tick(1);
        chk("comm_start_ignored_sel", 32'(sel), 32'd0);
        chk("comm_start_ignored_en", 32'(en), 32'b01);
        src_valid = 1'b1;
        tick(3);
        src_valid = 1'b0;
        buf_full = 1'b1;
        tick(1);
        chk("wait_state", 32'(state), 32'd2);
        chk("wait_en", 32'(en), 32'd0);
        chk("wait_cnt", 32'(word_cnt), 32'd3);
        src_valid = 1'b1;
        tick(2);
        chk("wait_no_count", 32'(word_cnt), 32'd3);
        src_valid = 1'b0;
        buf_full = 1'b0;
        tick(1);
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_en", 32'(en), 32'b01);
        chk("resume_cnt", 32'(word_cnt), 32'd3);
    endtask

    task automatic test_drain;
        buf_full = 1'b1;
        tick(1);
        chk("drain_pre_wait", 32'(state), 32'd2);
        stop = 1'b1;
        buf_empty = 1'b0;
        tick(1);
        chk("drain_from_wait", 32'(state), 32'd3);
        tick(3);
        chk("drain_hold", 32'(state), 32'd3);
        buf_empty = 1'b1;
        dout_valid = 1'b1;
        dout = 16'h0000;
        tick(1);
        chk("drain_hold_valid", 32'(state), 32'd3);
        dout_valid = 1'b0;
        tick(1);
        chk("drain_exit_state", 32'(state), 32'd0);
        chk("drain_exit_busy", 32'(busy), 32'd0);
        stop = 1'b0;
        buf_full = 1'b0;
        start = 2'b00;
        tick(1);
    endtask

    task automatic test_parity;
        dout_valid = 1'b1;
        dout = 16'h0001;
        tick(1);
        chk("parity_even_0001", 32'(parity), 32'd1);
        chk("parity_odd_0001", 32'(parity_b), 32'd0);
        dout = 16'h0003;
        tick(1);
        chk("parity_even_0003", 32'(parity), 32'd0);
        chk("parity_odd_0003", 32'(parity_b), 32'd1);
        dout_valid = 1'b0;
        dout = 16'h0001;
        tick(1);
        chk("parity_even_held", 32'(parity), 32'd0);
        chk("parity_odd_held", 32'(parity_b), 32'd1);
    endtask

    task automatic test_saturation;
        start = 2'b10;
        tick(1);
        src_valid = 1'b1;
        tick(65535 + 3);
        src_valid = 1'b0;
        tick(1);
        chk("sat_word_cnt", 32'(word_cnt), 32'h0000_FFFF);
        chk("sat_state", 32'(state), 32'd1);
        stop = 1'b1;
        tick(2);
        chk("sat_end_idle", 32'(state), 32'd0);
        stop = 1'b0;
        start = 2'b00;
        tick(1);
    endtask

    task automatic test_timeout;
        start = 2'b01;
        tick(1);
        stop = 1'b1;
        buf_empty = 1'b0;
        tick(1);
        chk("to_enter_drain", 32'(state), 32'd3);
`ifdef STREAM_DRAIN_TIMEOUT_EN
        tick(7);
        chk("to_still_drain", 32'(state), 32'd3);
        chk("to_flag_clear", 32'(drain_to), 32'd0);
        tick(1);
        chk("to_forced_idle", 32'(state), 32'd0);
        chk("to_flag_set", 32'(drain_to), 32'd1);
        tick(2);
        chk("to_flag_sticky", 32'(drain_to), 32'd1);
        stop = 1'b0;
        start = 2'b00;
        tick(1);
        start = 2'b10;
        tick(1);
        chk("to_flag_cleared_by_start", 32'(drain_to), 32'd0);
        chk("to_new_session", 32'(state), 32'd1);
        start = 2'b00;
        stop = 1'b1;
        buf_empty = 1'b1;
        tick(2);
`else
        tick(20);
        chk("to_no_timeout_state", 32'(state), 32'd3);
        chk("to_tied_zero", 32'(drain_to), 32'd0);
        buf_empty = 1'b1;
        tick(1);
        chk("to_manual_exit", 32'(state), 32'd0);
`endif
        stop = 1'b0;
        start = 2'b00;
        buf_empty = 1'b1;
        tick(1);
    endtask

    task automatic test_async_reset;
        start = 2'b01;
        tick(1);
        src_valid = 1'b1;
        dout_valid = 1'b1;
        dout = 16'h0001;
        tick(2);
        src_valid = 1'b0;
        dout_valid = 1'b0;
        chk("pre_rst_state", 32'(state), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_en", 32'(en), 32'd0);
        chk("arst_word_cnt", 32'(word_cnt), 32'd0);
        chk("arst_parity", 32'(parity), 32'd0);
        start = 2'b00;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        start = 2'b00;
        stop = 1'b0;
        buf_full = 1'b0;
        buf_empty = 1'b1;
        src_valid = 1'b0;
        dout_valid = 1'b0;
        dout = 16'h0000;
        tick(2);
        test_reset;
        rst = 1'b0;
        tick(1);
        test_session;
        test_simultaneous;
        test_backpressure;
        test_drain;
        test_parity;
        test_saturation;
        test_timeout;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
